// File: rtl/msrh_conf_pkg.sv
// rtl/msrh_conf_pkg.sv - core configuration constants
package msrh_conf_pkg;

   localparam int RV_BRU_ENTRY_SIZE = 16;

endpackage

// File: rtl/msrh_pkg.sv
// rtl/msrh_pkg.sv - shared types and the ROB/BRU age compare
package msrh_pkg;

   localparam int RNID_W      = 7;
   localparam int CMT_ID_W    = 7;
   localparam int BRTAG_W     = $clog2(msrh_conf_pkg::RV_BRU_ENTRY_SIZE);
   localparam int RN_ENTRIES  = 32;

   typedef logic [BRTAG_W-1:0]  brtag_t;
   typedef logic [RNID_W-1:0]   rnid_t;
   typedef logic [CMT_ID_W-1:0] cmt_id_t;

   typedef enum logic [1:0] {
      RN_RESTORE_IDLE  = 2'd0,
      RN_RESTORE_RD    = 2'd1,
      RN_RESTORE_APPLY = 2'd2
   } rn_restore_state_t;

   // The MSB is a wrap bit, so the low-bit ordering flips when the MSBs differ.
   function automatic logic id0_is_older(cmt_id_t a, cmt_id_t b);
      logic older;
      if (a[CMT_ID_W-1] == b[CMT_ID_W-1]) begin
         older = a[CMT_ID_W-2:0] < b[CMT_ID_W-2:0];
      end else begin
         older = a[CMT_ID_W-2:0] > b[CMT_ID_W-2:0];
      end
      return older;
   endfunction

endpackage

// File: rtl/msrh_rn_map_restore.sv
// rtl/msrh_rn_map_restore.sv - restores the speculative rename map on mispredict or commit flush
module msrh_rn_map_restore #(
   parameter int BRTAG_SIZE = msrh_conf_pkg::RV_BRU_ENTRY_SIZE,
   parameter int RNID_W     = msrh_pkg::RNID_W,
   parameter int CMT_ID_W   = msrh_pkg::CMT_ID_W
) (
   input  logic                             i_clk,
   input  logic                             i_reset_n,
   input  logic                             i_br_upd_valid,
   input  logic                             i_br_upd_mispred,
   input  logic [$clog2(BRTAG_SIZE)-1:0]    i_br_upd_brtag,
   input  logic [CMT_ID_W-1:0]              i_br_upd_cmt_id,
   output logic [$clog2(BRTAG_SIZE)-1:0]    o_snap_brtag,
   input  logic [31:0][RNID_W-1:0]          i_snap_rn_list,
   input  logic                             i_cmt_flush,
   input  logic [31:0][RNID_W-1:0]          i_cmt_rn_list,
   output logic                             o_restore_valid,
   output logic [31:0][RNID_W-1:0]          o_restore_rn_list,
   output logic                             o_disp_stall,
   output logic                             o_busy
);

   localparam int BRTAG_W = $clog2(BRTAG_SIZE);

   msrh_pkg::rn_restore_state_t state_q, state_d;
   logic [BRTAG_W-1:0]          brtag_q, brtag_d;
   logic [CMT_ID_W-1:0]         cmt_id_q, cmt_id_d;
   logic [31:0][RNID_W-1:0]     data_q, data_d;
   logic                        restore_valid_q, restore_valid_d;

   logic mispred;
   logic mispred_older;

   assign mispred       = i_br_upd_valid & i_br_upd_mispred;
   assign mispred_older = mispred & msrh_pkg::id0_is_older(i_br_upd_cmt_id, cmt_id_q);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q         <= msrh_pkg::RN_RESTORE_IDLE;
         brtag_q         <= '0;
         cmt_id_q        <= '0;
         data_q          <= '0;
         restore_valid_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         brtag_q         <= brtag_d;
         cmt_id_q        <= cmt_id_d;
         data_q          <= data_d;
         restore_valid_q <= restore_valid_d;
      end
   end

   // data_q doubles as the restore payload; restore_valid_q marks the cycle it is installed.
   always_comb begin
      state_d         = state_q;
      brtag_d         = brtag_q;
      cmt_id_d        = cmt_id_q;
      data_d          = data_q;
      restore_valid_d = 1'b0;
      if (i_cmt_flush) begin
         state_d         = msrh_pkg::RN_RESTORE_IDLE;
         data_d          = i_cmt_rn_list;
         restore_valid_d = 1'b1;
      end else begin
         case (state_q)
            msrh_pkg::RN_RESTORE_IDLE: begin
               if (mispred) begin
                  brtag_d  = i_br_upd_brtag;
                  cmt_id_d = i_br_upd_cmt_id;
                  state_d  = msrh_pkg::RN_RESTORE_RD;
               end
            end
            msrh_pkg::RN_RESTORE_RD: begin
               if (mispred_older) begin
                  brtag_d  = i_br_upd_brtag;
                  cmt_id_d = i_br_upd_cmt_id;
               end else begin
                  data_d          = i_snap_rn_list;
                  restore_valid_d = 1'b1;
                  state_d         = msrh_pkg::RN_RESTORE_APPLY;
               end
            end
            msrh_pkg::RN_RESTORE_APPLY: begin
               if (mispred_older) begin
                  brtag_d  = i_br_upd_brtag;
                  cmt_id_d = i_br_upd_cmt_id;
                  state_d  = msrh_pkg::RN_RESTORE_RD;
               end else begin
                  state_d = msrh_pkg::RN_RESTORE_IDLE;
               end
            end
            default: state_d = msrh_pkg::RN_RESTORE_IDLE;
         endcase
      end
   end

   assign o_snap_brtag      = brtag_q;
   assign o_restore_valid   = restore_valid_q;
   assign o_restore_rn_list = data_q;
   assign o_busy            = (state_q != msrh_pkg::RN_RESTORE_IDLE);
   // Flush restores land while IDLE, so the strobe itself also holds the stall.
   assign o_disp_stall      = o_busy | mispred | i_cmt_flush | restore_valid_q;

endmodule

// File: tb/tb_msrh_rn_map_restore.sv
// tb/tb_msrh_rn_map_restore.sv - directed-vector bench for msrh_rn_map_restore
module tb_msrh_rn_map_restore;

   localparam int RNID_W = 7;

   logic                   clk;
   logic                   rst_n;
   logic                   br_valid;
   logic                   br_mispred;
   logic [3:0]             br_tag;
   logic [6:0]             br_cmt;
   logic [3:0]             snap_brtag;
   logic [31:0][RNID_W-1:0] snap_list;
   logic                   flush;
   logic [31:0][RNID_W-1:0] cmt_list;
   logic                   rv;
   logic [31:0][RNID_W-1:0] rlist;
   logic                   stall;
   logic                   busy;

   int n_vec;
   int n_err;

   msrh_rn_map_restore dut (
      .i_clk             (clk),
      .i_reset_n         (rst_n),
      .i_br_upd_valid    (br_valid),
      .i_br_upd_mispred  (br_mispred),
      .i_br_upd_brtag    (br_tag),
      .i_br_upd_cmt_id   (br_cmt),
      .o_snap_brtag      (snap_brtag),
      .i_snap_rn_list    (snap_list),
      .i_cmt_flush       (flush),
      .i_cmt_rn_list     (cmt_list),
      .o_restore_valid   (rv),
      .o_restore_rn_list (rlist),
      .o_disp_stall      (stall),
      .o_busy            (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Snapshot store: entry i of tag t holds i + 8*t + 8 (tag 3 gives i+32).
   always_comb begin
      for (int i = 0; i < 32; i++) snap_list[i] = 7'(i + 8 * int'(snap_brtag) + 8);
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic mp(input logic [3:0] t, input logic [6:0] c);
      br_valid   = 1'b1;
      br_mispred = 1'b1;
      br_tag     = t;
      br_cmt     = c;
   endtask

   task automatic idle_in();
      br_valid   = 1'b0;
      br_mispred = 1'b0;
      br_tag     = '0;
      br_cmt     = '0;
      flush      = 1'b0;
   endtask

   logic [31:0][RNID_W-1:0] all11;

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      idle_in();
      cmt_list = '0;
      for (int i = 0; i < 32; i++) all11[i] = 7'h11;
      cyc(); cyc();
      smp();
      chk("rst_rv", rv, 0);
      chk("rst_stall", stall, 0);
      chk("rst_busy", busy, 0);
      chk("rst_brtag", snap_brtag, 0);
      chk("rst_list", rlist, 0);
      cyc();
      rst_n = 1'b1;
      cyc();

      // 1: basic mispredict
      mp(4'd3, 7'h05);
      smp(); chk("t1_stall_T", stall, 1); chk("t1_rv_T", rv, 0);
      cyc(); idle_in();
      smp(); chk("t1_brtag_T1", snap_brtag, 3); chk("t1_busy_T1", busy, 1);
      chk("t1_stall_T1", stall, 1); chk("t1_rv_T1", rv, 0);
      cyc();
      smp(); chk("t1_rv_T2", rv, 1); chk("t1_e10", rlist[10], 42);
      chk("t1_e0", rlist[0], 32); chk("t1_stall_T2", stall, 1);
      cyc();
      smp(); chk("t1_stall_T3", stall, 0); chk("t1_rv_T3", rv, 0); chk("t1_busy_T3", busy, 0);

      // 2: correct prediction ignored
      br_valid = 1'b1; br_mispred = 1'b0; br_tag = 4'd5; br_cmt = 7'h09;
      smp(); chk("t2_stall", stall, 0);
      cyc(); idle_in();
      smp(); chk("t2_busy", busy, 0); chk("t2_rv", rv, 0); chk("t2_brtag", snap_brtag, 3);

      // 3: older mispredict in RD replaces the pending one
      cyc();
      mp(4'd2, 7'h10);
      cyc(); mp(4'd7, 7'h08);
      smp(); chk("t3_rv_T1", rv, 0);
      cyc(); idle_in();
      smp(); chk("t3_brtag_T2", snap_brtag, 7); chk("t3_rv_T2", rv, 0); chk("t3_busy_T2", busy, 1);
      cyc();
      smp(); chk("t3_rv_T3", rv, 1); chk("t3_e10", rlist[10], 74);
      cyc();
      smp(); chk("t3_rv_T4", rv, 0); chk("t3_busy_T4", busy, 0);

      // 4: younger mispredict in RD is dropped
      mp(4'd2, 7'h08);
      cyc(); mp(4'd7, 7'h10);
      cyc(); idle_in();
      smp(); chk("t4_rv_T2", rv, 1); chk("t4_e10", rlist[10], 34); chk("t4_brtag", snap_brtag, 2);
      cyc();
      smp(); chk("t4_rv_T3", rv, 0); chk("t4_busy_T3", busy, 0);
      // wrap: 0x02 is younger than 0x7E
      mp(4'd2, 7'h7E);
      cyc(); mp(4'd7, 7'h02);
      cyc(); idle_in();
      smp(); chk("t4w_rv", rv, 1); chk("t4w_e10", rlist[10], 34);
      cyc();
      smp(); chk("t4w_rv_after", rv, 0);
      // wrap reversed: 0x7E is older than 0x02
      mp(4'd7, 7'h02);
      cyc(); mp(4'd2, 7'h7E);
      cyc(); idle_in();
      smp(); chk("t4r_rv_T2", rv, 0); chk("t4r_brtag", snap_brtag, 2);
      cyc();
      smp(); chk("t4r_rv_T3", rv, 1); chk("t4r_e10", rlist[10], 34);
      cyc();

      // older mispredict during APPLY: restore fires, then re-reads
      mp(4'd2, 7'h10);
      cyc(); idle_in();
      cyc(); mp(4'd5, 7'h04);
      smp(); chk("tap_rv", rv, 1); chk("tap_e10", rlist[10], 34);
      cyc(); idle_in();
      smp(); chk("tap_rd_rv", rv, 0); chk("tap_busy", busy, 1); chk("tap_brtag", snap_brtag, 5);
      cyc();
      smp(); chk("tap_rv2", rv, 1); chk("tap_e10b", rlist[10], 58);
      cyc();

      // 5: flush during RD
      mp(4'd4, 7'h01);
      cyc(); idle_in(); flush = 1'b1; cmt_list = all11;
      smp(); chk("t5_stall_flush", stall, 1);
      cyc(); idle_in(); cmt_list = '0;
      smp(); chk("t5_rv", rv, 1); chk("t5_list", rlist, all11);
      chk("t5_busy", busy, 0); chk("t5_stall", stall, 1);
      for (int k = 0; k < 3; k++) begin
         cyc();
         smp(); chk("t5_no_br_rv", rv, 0); chk("t5_idle", busy, 0);
      end

      // back-to-back flushes, with a same-cycle mispredict ignored
      cyc(); flush = 1'b1; cmt_list = all11; mp(4'd6, 7'h03);
      cyc(); idle_in(); flush = 1'b1; cmt_list = '0;
      smp(); chk("bb_rv1", rv, 1); chk("bb_list1", rlist, all11); chk("bb_busy1", busy, 0);
      cyc(); idle_in();
      smp(); chk("bb_rv2", rv, 1); chk("bb_list2", rlist, 0);
      cyc();
      smp(); chk("bb_rv3", rv, 0); chk("bb_stall3", stall, 0);

      // 6: async reset mid-APPLY
      cyc();
      mp(4'd3, 7'h05);
      cyc(); idle_in();
      cyc();
      chk("t6_apply_rv", rv, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rv", rv, 0); chk("t6_busy", busy, 0); chk("t6_stall", stall, 0);
      chk("t6_brtag", snap_brtag, 0); chk("t6_list", rlist, 0);
      cyc(); cyc();
      rst_n = 1'b1;
      cyc();
      mp(4'd6, 7'h20);
      cyc(); idle_in();
      smp(); chk("t6_brtag_new", snap_brtag, 6);
      cyc();
      smp(); chk("t6_rv_new", rv, 1); chk("t6_e10_new", rlist[10], 66);
      cyc();
      smp(); chk("t6_done", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
